jtopl_sh_ring: RTL
==================

JTOPL_SH_RING -- requirements
Module: jtopl_sh_ring

Interface
REQ-001 Parameter WIDTH, default 5, bits per slot entry.
REQ-002 Parameter STAGES, default 18, shift depth and slot count; legal range 3..64.
REQ-003 Parameter RSTVAL, default 0, WIDTH-bit value loaded into every stage by reset or clr.
REQ-004 Parameter TAP, default 0, stage index driven on tap; 0 = newest entry; legal range 0..STAGES-1.
REQ-005 Parameter RING, default 1: 1 = recirculating mode, 0 = plain delay-line mode.
REQ-006 Ports, in this order:
- clk, input, 1: clock; rising edge only.
- rst_n, input, 1: asynchronous active-low reset.
- cen, input, 1: clock enable; all state advances only on clk edges with cen=1.
- clr, input, 1: synchronous clear of all stages, qualified by cen.
- din, input, WIDTH: data entering stage 0.
- we, input, 1: write request, used in RING=1 only.
- wr_slot, input, SW: target slot for we; SW = clog2(STAGES).
- drop, output, WIDTH: last stage (STAGES-1).
- tap, output, WIDTH: stage TAP.
- slot, output, SW: slot index currently at the input and output.
- zero, output, 1: high when slot==0.

Function
REQ-007 Storage: STAGES x WIDTH shift chain; with cen=1, stage n+1 takes stage n and stage 0 takes the entry value; with cen=0, all state holds.
REQ-008 Entry value, RING=0: din.
REQ-009 Entry value, RING=1: din when we=1 and wr_slot==slot; otherwise drop, i.e. recirculate.
REQ-010 Priority when clr=1 and cen=1: all stages load RSTVAL; clr overrides we and din in both modes.
REQ-011 Slot counter: increments on each cen, wrapping STAGES-1 -> 0, and never holds a value >= STAGES.
REQ-012 Slot identity: drop is the value written or recirculated for the same slot index STAGES cen pulses earlier, so drop always belongs to slot.
REQ-013 Delay latency, RING=0: din sampled on cen edge k appears on drop after edge k+STAGES-1 and is valid during the interval before edge k+STAGES.
REQ-014 Ring latency, RING=1: a written value reappears on drop every STAGES cen pulses until overwritten or cleared.
REQ-015 Writes to a non-matching slot: a wr_slot >= STAGES never matches and is ignored without error.
REQ-016 Write hold: we held for a full rotation writes exactly one slot, the one where wr_slot==slot.
REQ-017 Output timing: drop, tap, slot and zero are direct register outputs with no combinational path from any input; zero is decoded from the slot register only.
REQ-018 clr and the slot counter: clr does not reset the counter.

Reset
REQ-019 Reset behaviour: rst_n=0 asynchronously forces all stages to RSTVAL and slot to 0, so zero=1 and drop=tap=RSTVAL.
REQ-020 Reset mid-operation: rst_n=0 asserted mid-rotation discards all content.
REQ-021 Restart: the first cen after release of rst_n treats slot 0 as the current slot.
REQ-022 No sync reset: the block has no synchronous reset path; clr is the only synchronous clear.

Structure
REQ-023 Shared package jtopl_pkg holds the OPL slot count constant (18) and a clog2 helper function used to derive SW.
REQ-024 Sub-module: the slot counter, with its wrap logic and zero decode, is one sub-module named jtopl_slot_cnt with parameter STAGES.
REQ-025 Elaboration checks: parameter range violations for STAGES and TAP produce an elaboration-time error.

Verification (WIDTH=5, STAGES=18, RSTVAL=0, TAP=3)
REQ-026 Reset: rst_n low mid-run with random content -> drop=tap=0, slot=0, zero=1 immediately, without a clk edge.
REQ-027 Delay line: RING=0; din=5'h1F on one cen edge, 0 otherwise -> drop=5'h1F exactly after the 18th cen edge and tap=5'h1F after the 4th; with cen gated 50%, timing is in cen pulses only.
REQ-028 Ring write: RING=1; we=1, wr_slot=7, din=5'h0A held for 18 cen -> drop=5'h0A only when slot=7, repeated over 3 rotations; all other slots stay 0.
REQ-029 Simultaneous clr and we: RING=1 ring loaded; clr=1 and we=1 (wr_slot=slot, din=5'h11) on the same cen -> next rotation all drop=0 and slot sequence uninterrupted.
REQ-030 Wrap and invalid slot: 40 cen pulses -> slot 0..17,0..17,0..3 and zero high on exactly 3 pulses; we=1 with wr_slot=31 for a full rotation -> ring content unchanged.

Source files
------------

// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL slot datapath: slot count and a clog2 helper
// used to size slot indices.
package jtopl_pkg;

    localparam int OPL_SLOTS = 18;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtopl_sh_ring_slot_cnt.sv
// Slot counter for the shift ring: counts cen pulses modulo STAGES and
// flags slot 0.
module jtopl_slot_cnt
    import jtopl_pkg::*;
#(
    parameter int STAGES = OPL_SLOTS,
    localparam int SW = clog2(STAGES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    output logic [SW-1:0] slot,
    output logic          zero
);

    localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (cen) begin
            slot <= (slot == LAST) ? '0 : slot + 1'b1;
        end
    end

    assign zero = (slot == '0);

endmodule

// File: rtl/jtopl_sh_ring.sv
// Per-slot shift register: a plain delay line (RING=0) or a recirculating
// ring where each slot can be rewritten as it passes the entry (RING=1).
module jtopl_sh_ring
    import jtopl_pkg::*;
#(
    parameter int              WIDTH  = 5,
    parameter int              STAGES = OPL_SLOTS,
    parameter logic [WIDTH-1:0] RSTVAL = '0,
    parameter int              TAP    = 0,
    parameter int              RING   = 1,
    localparam int             SW     = clog2(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             we,
    input  logic [SW-1:0]    wr_slot,
    output logic [WIDTH-1:0] drop,
    output logic [WIDTH-1:0] tap,
    output logic [SW-1:0]    slot,
    output logic             zero
);

    generate
        if (STAGES < 3 || STAGES > 64) begin : g_bad_stages
            $error("jtopl_sh_ring: STAGES must be in 3..64");
        end
        if (TAP < 0 || TAP > STAGES - 1) begin : g_bad_tap
            $error("jtopl_sh_ring: TAP must be in 0..STAGES-1");
        end
    endgenerate

    logic [WIDTH-1:0] st [STAGES];
    logic [WIDTH-1:0] entry;

    // The last stage always holds the current slot's value, so recirculating
    // it keeps every slot aligned with the counter.
    always_comb begin
        entry = din;
        if (RING != 0 && !(we && wr_slot == slot)) entry = st[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) st[i] <= RSTVAL;
        end else if (cen) begin
            if (clr) begin
                for (int i = 0; i < STAGES; i++) st[i] <= RSTVAL;
            end else begin
                st[0] <= entry;
                for (int i = 1; i < STAGES; i++) st[i] <= st[i-1];
            end
        end
    end

    assign drop = st[STAGES-1];
    assign tap  = st[TAP];

    jtopl_slot_cnt #(.STAGES(STAGES)) u_slot_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .cen  (cen),
        .slot (slot),
        .zero (zero)
    );

endmodule
